maquina_cafe_param: RTL and testbench
=====================================

# maquina_cafe_param

Parameterised coffee-machine controller: the next generation of the single-recipe, fixed-constant controller. It adds a power-on preheat, a strobed access code with wrong-attempt lockout, three configurable cup sizes with latched selection, a sized reservoir that can pause and resume a brew through refill, and a done pulse. It sits between the front-panel inputs and the pump/thermoblock drivers.

## Interface
- CODE_W, 7: access-code width.
- CODE, 17: accepted access code.
- HEAT_CYC, 5: preheat cycles, ≥1.
- SHORT_CYC / MED_CYC / LONG_CYC, 2 / 4 / 6: pump cycles per size, 1..255.
- RES_W, 4: reservoir level width.
- RES_FULL, 10: level after refill or reset, 1..2^RES_W−1.
- MAX_TRIES, 3: wrong codes before lockout, ≥1.
- LOCK_CYC, 10: lockout duration in cycles, ≥1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- power  in  1  level; 0 forces OFF.
- codigo  in  CODE_W  code value, sampled only when code_valid=1.
- code_valid  in  1  one-cycle code submit strobe.
- selecao  in  2  00 none, 01 short, 10 medium, 11 long.
- start  in  1  brew/resume request.
- refill  in  1  reservoir refilled.
- bomba  out  1  pump drive.
- termobloco  out  1  heater drive.
- reservatorio  out  RES_W  current level.
- estado  out  4  current state code.
- pronto  out  1  cup-complete pulse.
- bloqueado  out  1  lockout active.

## Operation
- States and encodings: OFF 0, HEAT 1, WAIT_CODE 2, CODE_OK 3, ARMED 4, BREW 5, REFILL 6, LOCKED 7, DONE 8.
- Priority: RST, then power=0, then the per-state logic. power=0 in any state sends the machine to OFF at the next edge and discards the remaining-cycle count. The reservoir level is retained.
- OFF → HEAT when power=1.
- HEAT: after HEAT_CYC cycles, go to WAIT_CODE.
- WAIT_CODE:
  - code_valid with codigo==CODE → CODE_OK and clear tries.
  - code_valid with a wrong code → tries+1. When tries reaches MAX_TRIES, go to LOCKED.
  - With no code_valid, stay.
- LOCKED: for LOCK_CYC cycles, ignore all code_valid. Then clear tries and go to WAIT_CODE.
- CODE_OK: a non-zero selecao latches the size and loads remaining (SHORT/MED/LONG_CYC), then → ARMED. selecao=00 stays.
- ARMED:
  - selecao=00 → CODE_OK (cancel).
  - Other selecao changes are ignored.
  - start → BREW if reservatorio>0, otherwise → REFILL.
- BREW: every cycle, reservatorio−1 and remaining−1.
  - If remaining==1 → DONE. This has priority when both counts reach 0 together.
  - Else if reservatorio==1 → REFILL, keeping remaining.
  - The level never underflows, because BREW is entered only with a non-zero level.
- REFILL:
  - refill=1 loads reservatorio=RES_FULL in the same cycle.
  - start=1 with reservatorio>0 (already stored) → BREW, resuming remaining.
  - Otherwise stay.
- DONE: one cycle, then → CODE_OK. The session stays authenticated.
- Outputs (all registered Moore outputs, decoded from the state):
  - bomba=1 iff BREW.
  - termobloco=1 iff HEAT or BREW.
  - pronto=1 iff DONE.
  - bloqueado=1 iff LOCKED.

## Timing
- Reset values: estado=0, bomba=0, termobloco=0, pronto=0, bloqueado=0, reservatorio=RES_FULL, tries=0, remaining=0.
- Each transition takes effect at the edge that samples its condition.
- A code strobe produces a state change one cycle later.
- Brew of N cycles with sufficient water:
  - bomba is high for exactly N consecutive cycles.
  - pronto is high in the cycle after the last pump cycle.
  - reservatorio drops by N.
- Simultaneous refill and start in REFILL: the level is reloaded and the state stays REFILL. BREW needs a later start.
- RST mid-brew: all values return to reset values at that edge.

## Configuration
- MAQ_CAFE_LOCKOUT_EN defined: the tries counter, the LOCKED state and bloqueado behave as described above.
- MAQ_CAFE_LOCKOUT_EN undefined:
  - Wrong codes leave the machine in WAIT_CODE indefinitely.
  - No tries counter is built.
  - bloqueado is tied to 0.
  - MAX_TRIES and LOCK_CYC are ignored.

## Test plan
- RST, power=1 → termobloco high for 5 cycles, then estado=2. code_valid with codigo=17 → estado=3 the next cycle.
- Authenticated, selecao=01, start → bomba high for 2 cycles, reservatorio 10→8, one-cycle pronto, estado=3.
- Three wrong code strobes (lockout enabled) → estado=7 and bloqueado high for 10 cycles. A correct code during lockout is ignored. Then estado=2.
- Reservoir at 4, long cup (6) → 4 pump cycles, reservatorio=0, estado=6, bomba=0. Then refill → reservatorio=10. Then start → 2 pump cycles, reservatorio=8, pronto.
- Power drop in the 2nd BREW cycle → estado=0 and bomba=0 the next cycle, reservatorio keeps its value. Power back on → HEAT again.
- RST asserted mid-BREW → all outputs at reset values the next cycle, reservatorio=10.

Source files
------------

// File: rtl/maquina_cafe_param.sv
// Parameterised coffee-machine controller: preheat, access code, three cup sizes, reservoir with refill/resume.
// Optional wrong-code lockout (tries counter, LOCKED state, bloqueado) is built only when MAQ_CAFE_LOCKOUT_EN is defined.
module maquina_cafe_param #(
    parameter int CODE_W    = 7,
    parameter int CODE      = 17,
    parameter int HEAT_CYC  = 5,
    parameter int SHORT_CYC = 2,
    parameter int MED_CYC   = 4,
    parameter int LONG_CYC  = 6,
    parameter int RES_W     = 4,
    parameter int RES_FULL  = 10,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYC  = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              power,
    input  logic [CODE_W-1:0] codigo,
    input  logic              code_valid,
    input  logic [1:0]        selecao,
    input  logic              start,
    input  logic              refill,
    output logic              bomba,
    output logic              termobloco,
    output logic [RES_W-1:0]  reservatorio,
    output logic [3:0]        estado,
    output logic              pronto,
    output logic              bloqueado
);

    typedef enum logic [3:0] {
        S_OFF       = 4'd0,
        S_HEAT      = 4'd1,
        S_WAIT_CODE = 4'd2,
        S_CODE_OK   = 4'd3,
        S_ARMED     = 4'd4,
        S_BREW      = 4'd5,
        S_REFILL    = 4'd6,
        S_LOCKED    = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    // Reject parameter sets outside their legal ranges at elaboration.
    if ((HEAT_CYC < 1) || (SHORT_CYC < 1) || (SHORT_CYC > 255) || (MED_CYC < 1) || (MED_CYC > 255) ||
        (LONG_CYC < 1) || (LONG_CYC > 255) || (RES_FULL < 1) || (RES_FULL > (2 ** RES_W) - 1) ||
        (MAX_TRIES < 1) || (LOCK_CYC < 1)) begin : g_bad_param
        $error("maquina_cafe_param: parameter out of range");
    end

    // One cycle counter is shared by HEAT and LOCKED; they are never active together.
    localparam int CNT_MAX = (HEAT_CYC > LOCK_CYC) ? HEAT_CYC : LOCK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  HEAT_LAST = CNT_W'(HEAT_CYC - 1);
    localparam logic [CODE_W-1:0] CODE_V    = CODE_W'(CODE);
    localparam logic [7:0]        SHORT_V   = 8'(SHORT_CYC);
    localparam logic [7:0]        MED_V     = 8'(MED_CYC);
    localparam logic [7:0]        LONG_V    = 8'(LONG_CYC);
    localparam logic [RES_W-1:0]  FULL_V    = RES_W'(RES_FULL);
    localparam logic [RES_W-1:0]  ONE_RES   = RES_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        rem_q, rem_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              bomba_q, termo_q, pronto_q;

`ifdef MAQ_CAFE_LOCKOUT_EN
    localparam int               TRIES_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_CYC - 1);
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic               bloq_q;
`endif

    // Next-state, counters and reservoir level; power loss overrides every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        res_d   = res_q;
`ifdef MAQ_CAFE_LOCKOUT_EN
        tries_d = tries_q;
`endif
        if (!power) begin
            state_d = S_OFF;
            cnt_d   = '0;
            rem_d   = 8'd0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_HEAT;
                    cnt_d   = '0;
                end
                S_HEAT: begin
                    if (cnt_q == HEAT_LAST) begin
                        state_d = S_WAIT_CODE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_CODE: begin
                    if (code_valid && (codigo == CODE_V)) begin
                        state_d = S_CODE_OK;
`ifdef MAQ_CAFE_LOCKOUT_EN
                        tries_d = '0;
`endif
                    end else if (code_valid) begin
`ifdef MAQ_CAFE_LOCKOUT_EN
                        tries_d = tries_q + 1'b1;
                        if (tries_q == TRIES_LAST) begin
                            state_d = S_LOCKED;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_WAIT_CODE;
                        end
`else
                        state_d = S_WAIT_CODE;
`endif
                    end else begin
                        state_d = S_WAIT_CODE;
                    end
                end
                S_LOCKED: begin
`ifdef MAQ_CAFE_LOCKOUT_EN
                    if (cnt_q == LOCK_LAST) begin
                        state_d = S_WAIT_CODE;
                        cnt_d   = '0;
                        tries_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    state_d = S_WAIT_CODE;
`endif
                end
                S_CODE_OK: begin
                    case (selecao)
                        2'b01: begin state_d = S_ARMED; rem_d = SHORT_V; end
                        2'b10: begin state_d = S_ARMED; rem_d = MED_V;   end
                        2'b11: begin state_d = S_ARMED; rem_d = LONG_V;  end
                        default: state_d = S_CODE_OK;
                    endcase
                end
                S_ARMED: begin
                    if (selecao == 2'b00) begin
                        state_d = S_CODE_OK;
                    end else if (start && (res_q != '0)) begin
                        state_d = S_BREW;
                    end else if (start) begin
                        state_d = S_REFILL;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_BREW: begin
                    res_d = res_q - ONE_RES;
                    rem_d = rem_q - 8'd1;
                    // Cup completion wins when water and cup run out on the same cycle.
                    if (rem_q == 8'd1) begin
                        state_d = S_DONE;
                    end else if (res_q == ONE_RES) begin
                        state_d = S_REFILL;
                    end else begin
                        state_d = S_BREW;
                    end
                end
                S_REFILL: begin
                    if (refill) begin
                        res_d = FULL_V;
                    end else begin
                        res_d = res_q;
                    end
                    // Resume checks the stored level, so a same-cycle refill needs a later start.
                    if (start && (res_q != '0)) begin
                        state_d = S_BREW;
                    end else begin
                        state_d = S_REFILL;
                    end
                end
                S_DONE: begin
                    state_d = S_CODE_OK;
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    rem_d   = 8'd0;
                end
            endcase
        end
    end

    // State, counters and Moore outputs decoded from the next state so they align with estado.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            rem_q    <= 8'd0;
            res_q    <= FULL_V;
            bomba_q  <= 1'b0;
            termo_q  <= 1'b0;
            pronto_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            res_q    <= res_d;
            bomba_q  <= (state_d == S_BREW);
            termo_q  <= (state_d == S_HEAT) || (state_d == S_BREW);
            pronto_q <= (state_d == S_DONE);
        end
    end

`ifdef MAQ_CAFE_LOCKOUT_EN
    // Wrong-attempt counter and lockout indicator.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tries_q <= '0;
            bloq_q  <= 1'b0;
        end else begin
            tries_q <= tries_d;
            bloq_q  <= (state_d == S_LOCKED);
        end
    end
    assign bloqueado = bloq_q;
`else
    assign bloqueado = 1'b0;
`endif

    assign estado       = state_q;
    assign bomba        = bomba_q;
    assign termobloco   = termo_q;
    assign pronto       = pronto_q;
    assign reservatorio = res_q;

endmodule

// File: tb/tb_maquina_cafe_param.sv
// Self-checking bench for maquina_cafe_param: directed sessions plus randomized cup sizes,
// checked against a water/cup arithmetic model (pump cycles = min(cup, level), refill, resume).
module tb_maquina_cafe_param;

    localparam int CODE_W    = 7;
    localparam int CODE      = 17;
    localparam int HEAT_CYC  = 5;
    localparam int SHORT_CYC = 2;
    localparam int MED_CYC   = 4;
    localparam int LONG_CYC  = 6;
    localparam int RES_W     = 4;
    localparam int RES_FULL  = 10;
    localparam int MAX_TRIES = 3;
    localparam int LOCK_CYC  = 10;

    logic              CLK = 1'b0;
    logic              RST;
    logic              power;
    logic [CODE_W-1:0] codigo;
    logic              code_valid;
    logic [1:0]        selecao;
    logic              start;
    logic              refill;
    logic              bomba;
    logic              termobloco;
    logic [RES_W-1:0]  reservatorio;
    logic [3:0]        estado;
    logic              pronto;
    logic              bloqueado;

    int n_checks = 0;
    int n_pass   = 0;
    int m_res    = RES_FULL;

    maquina_cafe_param #(
        .CODE_W(CODE_W), .CODE(CODE), .HEAT_CYC(HEAT_CYC), .SHORT_CYC(SHORT_CYC),
        .MED_CYC(MED_CYC), .LONG_CYC(LONG_CYC), .RES_W(RES_W), .RES_FULL(RES_FULL),
        .MAX_TRIES(MAX_TRIES), .LOCK_CYC(LOCK_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .power(power), .codigo(codigo), .code_valid(code_valid),
        .selecao(selecao), .start(start), .refill(refill), .bomba(bomba),
        .termobloco(termobloco), .reservatorio(reservatorio), .estado(estado),
        .pronto(pronto), .bloqueado(bloqueado)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int cup_cycles(input int sel);
        case (sel)
            1:       return SHORT_CYC;
            2:       return MED_CYC;
            default: return LONG_CYC;
        endcase
    endfunction

    function automatic logic [CODE_W-1:0] wrong_code();
        int v;
        v = $urandom_range(0, (1 << CODE_W) - 2);
        if (v >= CODE) v++;
        return CODE_W'(v);
    endfunction

    task automatic heat_up();
        int n;
        int g;
        power = 1'b1;
        tick();
        n = 0;
        g = 0;
        while (estado == 4'd1 && g < 50) begin
            n += int'(termobloco);
            g++;
            tick();
        end
        check("heat_cycles", n, HEAT_CYC);
        check("after_heat_state", estado, 2);
        check("after_heat_termo", termobloco, 0);
    endtask

    task automatic enter_code();
        codigo = CODE_W'(CODE);
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        codigo = wrong_code();
        check("code_ok_state", estado, 3);
    endtask

    task automatic brew(input int sel);
        int n;
        int want;
        int pumps;
        int g;
        n = cup_cycles(sel);
        selecao = sel[1:0];
        tick();
        check("armed_state", estado, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        selecao = 2'b00;
        while (n > 0) begin
            want = (n < m_res) ? n : m_res;
            pumps = 0;
            g = 0;
            while (estado == 4'd5 && g < 300) begin
                pumps += int'(bomba);
                g++;
                tick();
            end
            check("pump_cycles", pumps, want);
            m_res -= want;
            n -= want;
            check("level", reservatorio, m_res);
            if (n == 0) begin
                check("pronto_high", pronto, 1);
                check("done_state", estado, 8);
                tick();
                check("back_to_code_ok", estado, 3);
                check("pronto_low", pronto, 0);
            end else begin
                check("refill_state", estado, 6);
                check("refill_pump_off", bomba, 0);
                refill = 1'b1;
                start = 1'($urandom_range(0, 1));
                tick();
                refill = 1'b0;
                start = 1'b0;
                m_res = RES_FULL;
                check("refilled_level", reservatorio, m_res);
                check("refill_holds", estado, 6);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
    endtask

    initial begin
        int lock_n;
        int g;
        RST = 1'b1; power = 1'b0; codigo = '0; code_valid = 1'b0;
        selecao = 2'b00; start = 1'b0; refill = 1'b0;
        tick();
        tick();
        check("rst_estado", estado, 0);
        check("rst_bomba", bomba, 0);
        check("rst_termo", termobloco, 0);
        check("rst_pronto", pronto, 0);
        check("rst_bloq", bloqueado, 0);
        check("rst_level", reservatorio, RES_FULL);
        RST = 1'b0;
        heat_up();

        // Wrong codes: two keep waiting, third locks (if built).
        for (int i = 0; i < MAX_TRIES - 1; i++) begin
            codigo = wrong_code();
            code_valid = 1'b1;
            tick();
            code_valid = 1'b0;
            check("wrong_code_wait", estado, 2);
        end
        codigo = wrong_code();
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
`ifdef MAQ_CAFE_LOCKOUT_EN
        check("locked_state", estado, 7);
        check("locked_flag", bloqueado, 1);
        lock_n = 0;
        g = 0;
        while (estado == 4'd7 && g < 100) begin
            lock_n += int'(bloqueado);
            codigo = CODE_W'(CODE);
            code_valid = (lock_n == 3);
            g++;
            tick();
        end
        code_valid = 1'b0;
        check("lock_cycles", lock_n, LOCK_CYC);
        check("after_lock_state", estado, 2);
        check("after_lock_flag", bloqueado, 0);
        codigo = wrong_code();
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        check("tries_cleared", estado, 2);
`else
        lock_n = 0;
        g = 0;
        check("no_lock_state", estado, 2);
        check("no_lock_flag", bloqueado, 0);
`endif
        enter_code();

        // Cancel from ARMED.
        selecao = 2'b01;
        tick();
        check("cancel_armed", estado, 4);
        selecao = 2'b00;
        tick();
        check("cancel_back", estado, 3);

        brew(1);

        // Power loss in the second pump cycle.
        selecao = 2'b01;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        selecao = 2'b00;
        check("pwr_brew1_pump", bomba, 1);
        tick();
        check("pwr_brew2_state", estado, 5);
        power = 1'b0;
        tick();
        m_res -= 1;
        check("pwr_off_state", estado, 0);
        check("pwr_off_pump", bomba, 0);
        check("pwr_off_level", reservatorio, m_res);
        heat_up();
        enter_code();

        brew(2);
        brew(3);
        for (int i = 0; i < 8; i++) begin
            brew($urandom_range(1, 3));
        end

        // Reset in the middle of a brew.
        selecao = 2'b01;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        selecao = 2'b00;
        check("pre_rst_state", estado, (m_res > 0) ? 5 : 6);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        power = 1'b0;
        check("mid_rst_estado", estado, 0);
        check("mid_rst_bomba", bomba, 0);
        check("mid_rst_termo", termobloco, 0);
        check("mid_rst_pronto", pronto, 0);
        check("mid_rst_bloq", bloqueado, 0);
        check("mid_rst_level", reservatorio, RES_FULL);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
